// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-requester arbiter in front of a single-port memory controller. Each
// access takes three cycles: IDLE (arbitrate and register the winner's
// command), ACCESS (command driven to memory, read data captured at its
// closing edge) and RESP (one-cycle ack/err to the owner). Ties go
// round-robin, and a requester that holds its lock keeps the bus for its next
// back-to-back request. Writes at or below ROM_TOP still take the bus but are
// suppressed towards memory and flagged with err.
//
// Ports
//   clock, reset           : single clock, synchronous active-high reset
//   reqN, weN, addrN,      : request N (held until ackN), write flag, word
//   wdataN, lockN          :   address, write data, keep-grant request
//   ackN, rdataN, errN     : completion pulse, read data (held until N's next
//                            read), blocked-write flag (valid with ackN)
//   mem_address,           : command to the memory controller; mem_we is only
//   mem_data_in, mem_we    :   ever high in ACCESS
//   mem_data_out           : read data from the memory controller
//   busy, grant_id         : FSM not in IDLE, current bus owner
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter logic [15:0] ROM_TOP = 16'h001F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data_out,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_served_q, last_served_d;
  logic        grant_id_q, grant_id_d;
  logic        wr_q, wr_d;          // granted command is a write
  logic        blocked_q, blocked_d; // granted write targets the ROM window
  logic [15:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  // Arbitration result, only consumed in IDLE.
  logic        any_req;
  logic        winner;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [31:0] sel_wdata;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      // The last owner keeps the bus while it holds its lock; otherwise the
      // requester not served last wins. A dropped req releases the lock
      // simply because this branch is no longer taken.
      if (last_served_q ? lock1 : lock0) winner = last_served_q;
      else                               winner = ~last_served_q;
    end else begin
      winner = req1;
    end
    sel_we    = winner ? we1    : we0;
    sel_addr  = winner ? addr1  : addr0;
    sel_wdata = winner ? wdata1 : wdata0;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      // NOTE: the data registers are reset as well, since rdata and the memory
      // command are visible outputs with defined post-reset values.
      state_q       <= IDLE;
      last_served_q <= 1'b1;   // requester 0 wins the first tie
      grant_id_q    <= 1'b0;
      wr_q          <= 1'b0;
      blocked_q     <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      grant_id_q    <= grant_id_d;
      wr_q          <= wr_d;
      blocked_q     <= blocked_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    last_served_d = last_served_q;
    grant_id_d    = grant_id_q;
    wr_d          = wr_q;
    blocked_d     = blocked_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = ACCESS;
          grant_id_d    = winner;
          last_served_d = winner;
          wr_d          = sel_we;
          blocked_d     = sel_we && (sel_addr <= ROM_TOP);
          mem_address_d = sel_addr;
          mem_data_in_d = sel_wdata;
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Only reads update the owner's rdata; writes leave it untouched.
        if (!wr_q) begin
          if (grant_id_q) rdata1_d = mem_data_out;
          else            rdata0_d = mem_data_out;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ack0   = 1'b0;
    ack1   = 1'b0;
    err0   = 1'b0;
    err1   = 1'b0;
    mem_we = 1'b0;
    busy   = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      ACCESS: begin
        // A blocked write still occupies the bus cycle, it just never strobes.
        mem_we = wr_q & ~blocked_q;
      end
      RESP: begin
        ack0 = ~grant_id_q;
        ack1 =  grant_id_q;
        err0 = ~grant_id_q & blocked_q;
        err1 =  grant_id_q & blocked_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios plus a short two-client random phase. Each request pushes
// its expected completion (read data, err, optionally the exact ack cycle)
// into a per-requester queue; an independent monitor pops and compares on
// every ack. The bench also plays the memory controller.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam logic [15:0] ROM_TOP = 16'h001F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic        lock0 = 1'b0, lock1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, mem_we, busy, grant_id;
  logic [31:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [15:0] mem_address;

  mem_bus_arbiter #(.ROM_TOP(ROM_TOP)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  // Cycle index: between posedge k and posedge k+1, cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory controller model (combinational read, write on posedge).
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  assign mem_data_out = mem[mem_address[11:0]];
  always @(posedge clock) if (mem_we) mem[mem_address[11:0]] <= mem_data_in;

  function automatic logic [31:0] init_val(input int a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
    int          cyc;    // -1: ack cycle not checked
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd [2];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic on_ack(input int id, input logic [31:0] rd, input logic er);
    exp_t e;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ack%0d (cycle %0d): got ack, want none", id, cyc);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    check($sformatf("err%0d", id), {31'b0, er}, {31'b0, e.err});
    if (e.rd) begin
      check($sformatf("rdata%0d", id), rd, e.rdata);
      last_rd[id] = e.rdata;
    end else begin
      check($sformatf("rdata%0d_hold", id), rd, last_rd[id]);
    end
    if (e.cyc >= 0) check($sformatf("ack%0d_cycle", id), cyc, e.cyc);
  endtask

  always @(negedge clock) begin
    if (!reset && (ack0 || ack1)) begin
      check("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
      if (ack0) on_ack(0, rdata0, err0);
      if (ack1) on_ack(1, rdata1, err1);
    end
  end

  // --------------------------------------------------------------------------
  // Requester driver: call at a negedge; returns at the negedge of its ack.
  // --------------------------------------------------------------------------
  task automatic do_req(input int id, input bit we, input logic [15:0] addr,
                        input logic [31:0] wd, input bit lk, input bit exp_err,
                        input logic [31:0] exp_rd, input int exp_cyc);
    exp_t e;
    bit   got;
    got     = 1'b0;
    e.rd    = !we;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = exp_cyc;
    if (id == 0) begin
      q0.push_back(e);
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; lock0 = lk;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; lock1 = lk;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = (id == 0) ? ack0 : ack1;
    end
    check($sformatf("ack%0d_handshake", id), {31'b0, got}, 32'd1);
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  // Random client: private RAM window per requester plus the shared ROM.
  task automatic rand_client(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      bit          we;
      bit          lk;
      bit          er;
      logic [15:0] a;
      logic [31:0] wd;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      we = 1'($urandom_range(0, 1));
      lk = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 31));
      else a = (id == 0 ? 16'h0100 : 16'h0200) + 16'($urandom_range(0, 3));
      wd = $urandom;
      er = we && (a <= ROM_TOP);
      if (we && !er) ref_mem[a[11:0]] = wd;
      do_req(id, we, a, wd, lk, er, ref_mem[a[11:0]], -1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int c;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     <= init_val(i);
      ref_mem[i]  = init_val(i);
    end
    mem[12'h800]     <= 32'hDEADBEEF;
    ref_mem[12'h800]  = 32'hDEADBEEF;
    last_rd[0] = '0;
    last_rd[1] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset values
    check("rst_ack0",        {31'b0, ack0},     32'd0);
    check("rst_ack1",        {31'b0, ack1},     32'd0);
    check("rst_err0",        {31'b0, err0},     32'd0);
    check("rst_err1",        {31'b0, err1},     32'd0);
    check("rst_mem_we",      {31'b0, mem_we},   32'd0);
    check("rst_busy",        {31'b0, busy},     32'd0);
    check("rst_grant_id",    {31'b0, grant_id}, 32'd0);
    check("rst_mem_address", {16'b0, mem_address}, 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_rdata0",      rdata0, 32'd0);
    check("rst_rdata1",      rdata1, 32'd0);

    // Both requesters held continuously: grants 0,1,0,1, acks every 3 cycles.
    c = cyc;
    fork
      begin
        do_req(0, 0, 16'h0100, 0, 0, 0, init_val(16'h0100), c + 2);
        do_req(0, 0, 16'h0101, 0, 0, 0, init_val(16'h0101), c + 8);
      end
      begin
        do_req(1, 0, 16'h0200, 0, 0, 0, init_val(16'h0200), c + 5);
        do_req(1, 0, 16'h0201, 0, 0, 0, init_val(16'h0201), c + 11);
      end
    join
    @(negedge clock);

    // Single read with command visible during ACCESS.
    c = cyc;
    fork
      do_req(0, 0, 16'h0800, 0, 0, 0, 32'hDEADBEEF, c + 2);
      begin
        @(negedge clock);
        check("rd_mem_address", {16'b0, mem_address}, 32'h0000_0800);
        check("rd_mem_we",      {31'b0, mem_we},      32'd0);
        check("rd_busy",        {31'b0, busy},        32'd1);
        check("rd_grant_id",    {31'b0, grant_id},    32'd0);
      end
    join
    @(negedge clock);

    // Write into ROM: bus cycle happens, strobe suppressed, err flagged.
    c = cyc;
    fork
      do_req(1, 1, 16'h0010, 32'h5, 0, 1, 0, c + 2);
      begin
        @(negedge clock);
        check("rom_we_access",   {31'b0, mem_we},   32'd0);
        check("rom_data_in",     mem_data_in,       32'h5);
        check("rom_grant_id",    {31'b0, grant_id}, 32'd1);
        @(negedge clock);
        check("rom_we_resp",     {31'b0, mem_we},   32'd0);
      end
    join
    check("rom_0010_unchanged", mem[12'h010], init_val(16'h0010));
    @(negedge clock);

    // First RAM address above ROM_TOP is writable.
    c = cyc;
    fork
      do_req(0, 1, 16'h0020, 32'hA0A0_0020, 0, 0, 0, c + 2);
      begin
        @(negedge clock);
        check("ram_we_access", {31'b0, mem_we}, 32'd1);
      end
    join
    ref_mem[12'h020] = 32'hA0A0_0020;
    check("ram_0020_written", mem[12'h020], 32'hA0A0_0020);
    @(negedge clock);

    // ROM_TOP itself is still blocked.
    c = cyc;
    do_req(1, 1, ROM_TOP, 32'hFFFF_FFFF, 0, 1, 0, c + 2);
    check("rom_001f_unchanged", mem[12'h01F], init_val(16'h001F));
    @(negedge clock);

    // Locked read-modify-write by requester 0 while requester 1 waits.
    c = cyc;
    fork
      begin
        do_req(0, 0, 16'h0900, 0, 1, 0, init_val(16'h0900), c + 2);
        do_req(0, 1, 16'h0900, init_val(16'h0900) + 1, 1, 0, 0, c + 5);
        do_req(0, 0, 16'h0900, 0, 0, 0, init_val(16'h0900) + 1, c + 11);
      end
      do_req(1, 0, 16'h0900, 0, 0, 0, init_val(16'h0900) + 1, c + 8);
    join
    ref_mem[12'h900] = init_val(16'h0900) + 1;
    @(negedge clock);

    // Reset in the ACCESS cycle of a write aborts it without an ack.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0800; wdata0 = 32'h1111_2222; lock0 = 1'b0;
    @(negedge clock);
    check("abort_we_access", {31'b0, mem_we}, 32'd1);
    check("abort_busy_access", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    req0  = 1'b0;
    we0   = 1'b0;
    @(negedge clock);
    check("abort_busy",        {31'b0, busy},   32'd0);
    check("abort_mem_we",      {31'b0, mem_we}, 32'd0);
    check("abort_ack0",        {31'b0, ack0},   32'd0);
    check("abort_rdata0",      rdata0,          32'd0);
    check("abort_mem_address", {16'b0, mem_address}, 32'd0);
    reset = 1'b0;
    ref_mem[12'h800] = 32'h1111_2222;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clock);

    // Random traffic from both requesters.
    fork
      rand_client(0, 25);
      rand_client(1, 25);
    join

    for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(negedge clock);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ROM_TOP, default 16'h001F: highest read-only address; writes at or below it are blocked.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1, input, 1 each: access request, held until the matching ack.
REQ-005 SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read; stable while req high.
REQ-006 SHALL have ports addr0/addr1, input, 16 each: word address; stable while req high.
REQ-007 SHALL have ports wdata0/wdata1, input, 32 each: write data; stable while req high.
REQ-008 SHALL have ports lock0/lock1, input, 1 each: keep the grant for the next back-to-back request, e.g. read-modify-write.
REQ-009 SHALL have ports ack0/ack1, output, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports rdata0/rdata1, output, 32 each: read data, valid in the ack cycle.
REQ-011 SHALL have ports err0/err1, output, 1 each: blocked-write flag, valid in the ack cycle.
REQ-012 SHALL have port mem_address, output, 16: address to the memory controller.
REQ-013 SHALL have port mem_data_in, output, 32: write data to the memory controller.
REQ-014 SHALL have port mem_we, output, 1: write enable to the memory controller.
REQ-015 SHALL have port mem_data_out, input, 32: read data from the memory controller.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port grant_id, output, 1: requester currently owning the bus.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS and RESP; it arbitrates only in IDLE and ignores req in ACCESS and RESP.
REQ-019 In IDLE, with any req high, it SHALL register the winner's addr, wdata and we onto the mem_* outputs, set grant_id, and move to ACCESS; with no req it stays in IDLE.
REQ-020 ACCESS SHALL last exactly one cycle, with mem_* outputs stable for the whole cycle; at its closing posedge mem_data_out is captured into the granted rdata register.
REQ-021 In RESP, ackN (N = grant_id) SHALL be 1 for one cycle and errN SHALL reflect the blocked-write check; then the FSM returns to IDLE.
REQ-022 Latency SHALL be req sampled in IDLE at cycle 0, ACCESS at cycle 1, ack at cycle 2, with at most one access per 3 cycles.
REQ-023 Arbitration SHALL be round-robin: if both req are high, the requester not served last wins; a lone req wins outright.
REQ-024 Lock SHALL take precedence over round-robin: in IDLE, if last_served = N, lockN = 1 and reqN = 1, N wins; if reqN = 0 in IDLE, the lock is released.
REQ-025 A write with addr <= ROM_TOP SHALL still run through ACCESS but with mem_we = 0, and errN SHALL be 1 with ackN.
REQ-026 Reads at any address, including unmapped ones, SHALL complete normally with err = 0; rdata is whatever mem_data_out returns.
REQ-027 rdataN SHALL hold its value until N's next read completes; on writes it is left unchanged.
REQ-028 mem_we SHALL be 1 only in ACCESS; in IDLE and RESP it is 0, with mem_address and mem_data_in holding their last values.
REQ-029 A requester still holding req high in the ack cycle SHALL be treated, at the following IDLE, as a new request.
REQ-030 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-031 On reset, state = IDLE, ack0 = ack1 = 0, err0 = err1 = 0, mem_we = 0, busy = 0, grant_id = 0, and last_served = 1 so requester 0 wins the first tie.
REQ-032 On reset, mem_address = 0, mem_data_in = 0, rdata0 = 0 and rdata1 = 0.
REQ-033 Reset asserted during ACCESS or RESP SHALL abort the access with no ack and return to IDLE next cycle; mem_we is 0 the cycle after reset is sampled.

Verification
REQ-034 req0 read at 0x0800 with memory returning 32'hDEADBEEF -> ACCESS at cycle 1 with mem_address = 0x0800, ack0 and rdata0 = DEADBEEF at cycle 2, err0 = 0.
REQ-035 req0 and req1 both held continuously after reset -> grant order 0, 1, 0, 1, with acks at cycles 2, 5, 8, 11.
REQ-036 req1 write of 32'h5 to 0x0010 -> mem_we = 0 throughout, ack1 = 1 with err1 = 1, memory unchanged.
REQ-037 lock0 = 1 with req0 read then write at 0x0900 while req1 is held -> both req0 accesses are served before req1; drop lock0 -> req1 served next.
REQ-038 Reset pulsed in the ACCESS cycle of a write to 0x0800 -> no ack, busy = 0 and mem_we = 0 the next cycle.
REQ-039 Random req/we/lock stimulus run with a scoreboard -> every request acked exactly once, acks never overlap, and every rdata matches the reference memory model.
